// File: rtl/nibble_link_pkg.sv
// Shared types and helpers for the host-side nibble link toward the chip pad ring.
// Word/latency legality is checked at elaboration by the top module using paramsOk().
package nibble_link_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_ISSUE = 2'd1,
        RX_DRAIN = 2'd2,
        RX_HOLD  = 2'd3
    } rx_state_t;

    function automatic int nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

    function automatic bit paramsOk(input int width, input int latency);
        return ((width % NIBBLE_W) == 0) && (width >= 8) && (latency >= 1) && (latency <= 7);
    endfunction

endpackage

// File: rtl/nibble_link_host_rx.sv
// Readback path: issues NIBBLES read enables, tracks them through a READ_LATENCY
// strobe delay line and reassembles the returned nibbles MSB first into a word.
module nibble_rx_path
    import nibble_link_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic                  inRxReq,
    input  logic                  inRxReady,
    input  logic [NIBBLE_W-1:0]   inPadData,
    output logic                  outPadReadEnable,
    output logic                  outRxBusy,
    output logic [WORD_WIDTH-1:0] outRxWord,
    output logic                  outRxValid
);

    localparam int NIBBLES = nibbles(WORD_WIDTH);
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NIBBLES - 1);

    rx_state_t               rxState_r;
    logic [CNT_W-1:0]        issueCount_r;
    logic [CNT_W-1:0]        captureCount_r;
    logic [READ_LATENCY-1:0] strobeLine_r;
    logic [WORD_WIDTH-1:0]   assembly_r;
    logic                    issue_s;
    logic                    capture_s;
    logic                    lastCapture_s;

    // Read-enable and capture strobes decoded from state and the delay line
    always_comb begin
        issue_s       = (rxState_r == RX_ISSUE);
        capture_s     = strobeLine_r[READ_LATENCY-1];
        lastCapture_s = capture_s && (captureCount_r == LAST_NIBBLE);
    end

    // RX FSM, strobe delay line and assembly register
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            rxState_r      <= RX_IDLE;
            issueCount_r   <= '0;
            captureCount_r <= '0;
            strobeLine_r   <= '0;
            assembly_r     <= '0;
        end else begin
            strobeLine_r <= (strobeLine_r << 1) | READ_LATENCY'(issue_s);
            if (capture_s) begin
                assembly_r     <= {assembly_r[WORD_WIDTH-NIBBLE_W-1:0], inPadData};
                captureCount_r <= lastCapture_s ? '0 : captureCount_r + CNT_W'(1);
            end
            case (rxState_r)
                RX_IDLE: begin
                    if (inRxReq) begin
                        rxState_r    <= RX_ISSUE;
                        issueCount_r <= '0;
                    end
                end
                RX_ISSUE: begin
                    if (issueCount_r == LAST_NIBBLE) begin
                        rxState_r    <= RX_DRAIN;
                        issueCount_r <= '0;
                    end else begin
                        issueCount_r <= issueCount_r + CNT_W'(1);
                    end
                end
                RX_DRAIN: begin
                    if (lastCapture_s) begin
                        rxState_r <= RX_HOLD;
                    end
                end
                RX_HOLD: begin
                    if (inRxReady) begin
                        rxState_r <= RX_IDLE;
                    end
                end
                default: begin
                    rxState_r <= RX_IDLE;
                end
            endcase
        end
    end

    // Pad and consumer outputs, forced quiet while reset is asserted
    always_comb begin
        if (inReset) begin
            outPadReadEnable = issue_s;
            outRxBusy        = (rxState_r != RX_IDLE);
            outRxValid       = (rxState_r == RX_HOLD);
            outRxWord        = assembly_r;
        end else begin
            outPadReadEnable = 1'b0;
            outRxBusy        = 1'b0;
            outRxValid       = 1'b0;
            outRxWord        = '0;
        end
    end

endmodule

// File: rtl/nibble_link_host.sv
// Host side of the nibble pad link: serialises TX words into MSB-first nibbles
// and hosts the independent readback path.
module nibble_link_host
    import nibble_link_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic [WORD_WIDTH-1:0] inTxWord,
    input  logic                  inTxValid,
    output logic                  outTxReady,
    output logic [NIBBLE_W-1:0]   outPadData,
    output logic                  outPadValid,
    input  logic                  inRxReq,
    output logic                  outRxBusy,
    output logic                  outPadReadEnable,
    input  logic [NIBBLE_W-1:0]   inPadData,
    output logic [WORD_WIDTH-1:0] outRxWord,
    output logic                  outRxValid,
    input  logic                  inRxReady
);

    localparam int NIBBLES = nibbles(WORD_WIDTH);
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NIBBLES - 1);

    if (!paramsOk(WORD_WIDTH, READ_LATENCY)) begin : gBadParams
        $error("nibble_link_host: WORD_WIDTH must be a multiple of 4 (>= 8), READ_LATENCY 1..7");
    end

    tx_state_t             txState_r;
    logic [WORD_WIDTH-1:0] txShift_r;
    logic [CNT_W-1:0]      txCount_r;
    logic                  txLast_s;
    logic                  txReady_s;
    logic                  txFire_s;
    logic                  padValid_s;
    logic [NIBBLE_W-1:0]   padData_s;

    // TX handshake and pad decode; a new word may load on the last nibble
    always_comb begin
        txLast_s  = (txState_r == TX_SHIFT) && (txCount_r == LAST_NIBBLE);
        txReady_s = ((txState_r == TX_IDLE) || txLast_s) && inReset;
        txFire_s  = txReady_s && inTxValid;
        if (inReset && (txState_r == TX_SHIFT)) begin
            padValid_s = 1'b1;
            padData_s  = txShift_r[WORD_WIDTH-1 -: NIBBLE_W];
        end else begin
            padValid_s = 1'b0;
            padData_s  = 4'h0;
        end
    end

    // TX FSM and shift register
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            txState_r <= TX_IDLE;
            txShift_r <= '0;
            txCount_r <= '0;
        end else begin
            case (txState_r)
                TX_IDLE: begin
                    if (txFire_s) begin
                        txState_r <= TX_SHIFT;
                        txShift_r <= inTxWord;
                        txCount_r <= '0;
                    end
                end
                TX_SHIFT: begin
                    if (txFire_s) begin
                        txShift_r <= inTxWord;
                        txCount_r <= '0;
                    end else begin
                        txShift_r <= {txShift_r[WORD_WIDTH-NIBBLE_W-1:0], 4'h0};
                        txCount_r <= txLast_s ? '0 : txCount_r + CNT_W'(1);
                        if (txLast_s) begin
                            txState_r <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    txState_r <= TX_IDLE;
                    txCount_r <= '0;
                end
            endcase
        end
    end

    assign outTxReady  = txReady_s;
    assign outPadValid = padValid_s;
    assign outPadData  = padData_s;

    nibble_rx_path #(
        .WORD_WIDTH  (WORD_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) rxPath (
        .inClock         (inClock),
        .inReset         (inReset),
        .inRxReq         (inRxReq),
        .inRxReady       (inRxReady),
        .inPadData       (inPadData),
        .outPadReadEnable(outPadReadEnable),
        .outRxBusy       (outRxBusy),
        .outRxWord       (outRxWord),
        .outRxValid      (outRxValid)
    );

endmodule
